serial_check_sched: RTL and testbench

//  Round-robin scheduler that shares one serial bit-stream checker FSM between NREQ requesters.

---
 rtl/serial_check_sched.sv | 174 +++++++++++++++++
 tb/tb_serial_check_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_check_sched.sv
// rtl/serial_check_sched.sv - round-robin sharing of one serial bit-stream checker
//
// Purpose:
//   Arbitrates NREQ requesters round-robin. The winner's WLEN-bit word is
//   latched, the checker is restarted, and the word is shifted in MSB first.
//   The checker's pass flag is then sampled and returned, tagged with the
//   requester id.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req[NREQ]           request level per requester
//   data[NREQ*WLEN]     word of requester i at [i*WLEN +: WLEN]
//   gnt[NREQ]           one-hot single-cycle pulse, word accepted
//   busy                high from grant cycle through done cycle
//   done                single-cycle pulse, result/done_id valid
//   done_id, result     finished requester id and verdict (held until next done)
//   chk_restart         restart the checker at the next posedge
//   chk_en, chk_bit     serial bit to the checker, consumed at posedge when chk_en
//   chk_ok              checker pass flag, only looked at in SAMPLE
module serial_check_sched #(
  parameter int NREQ = 2,
  parameter int WLEN = 8,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WLEN-1:0] data,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 done,
  output logic [IDW-1:0]       done_id,
  output logic                 result,
  output logic                 chk_restart,
  output logic                 chk_en,
  output logic                 chk_bit,
  input  logic                 chk_ok
);

  localparam int CW = $clog2(WLEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESTART,
    S_SHIFT,
    S_SAMPLE,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [WLEN-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              result_q, result_d;
  logic [IDW-1:0]    done_id_q, done_id_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              chk_restart_q, chk_restart_d;
  logic              chk_en_q, chk_en_d;
  logic              chk_bit_q, chk_bit_d;

  logic              found;
  logic [IDW-1:0]    pick;

  // First set request at or above the rr pointer, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    done_id_d = done_id_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          id_d    = pick;
          shreg_d = data[int'(pick)*WLEN +: WLEN];
          state_d = S_RESTART;
        end
      end
      S_RESTART: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WLEN - 1)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        result_d  = chk_ok;
        done_id_d = id_q;
        state_d   = S_FINISH;
      end
      S_FINISH: begin
        rr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: decode them from the state being entered so
    // they line up with the state they belong to. chk_bit comes from the
    // shift register as it will be in that cycle (unshifted on entry).
    gnt_d = '0;
    if (state_d == S_RESTART) gnt_d[id_d] = 1'b1;
    chk_restart_d = (state_d == S_RESTART);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_FINISH);
    chk_en_d      = (state_d == S_SHIFT);
    chk_bit_d     = (state_d == S_SHIFT) & shreg_d[WLEN-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_q          <= '0;
      id_q          <= '0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      result_q      <= 1'b0;
      done_id_q     <= '0;
      gnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      chk_restart_q <= 1'b0;
      chk_en_q      <= 1'b0;
      chk_bit_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      id_q          <= id_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      result_q      <= result_d;
      done_id_q     <= done_id_d;
      gnt_q         <= gnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      chk_restart_q <= chk_restart_d;
      chk_en_q      <= chk_en_d;
      chk_bit_q     <= chk_bit_d;
    end
  end

  assign gnt         = gnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_id     = done_id_q;
  assign result      = result_q;
  assign chk_restart = chk_restart_q;
  assign chk_en      = chk_en_q;
  assign chk_bit     = chk_bit_q;

endmodule

// File: tb/tb_serial_check_sched.sv
// tb/tb_serial_check_sched.sv - scoreboard bench for serial_check_sched
module tb_serial_check_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] data = 16'h0000;
  logic [1:0]  gnt;
  logic        busy, done, done_id, result;
  logic        chk_restart, chk_en, chk_bit, chk_ok;

  serial_check_sched #(.NREQ(2), .WLEN(8), .IDW(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .result(result),
    .chk_restart(chk_restart), .chk_en(chk_en), .chk_bit(chk_bit), .chk_ok(chk_ok)
  );

  always #5 clk = ~clk;

  // Checker model: pass iff an even number of 1s since restart.
  logic par;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          par <= 1'b0;
    else if (chk_restart) par <= 1'b0;
    else if (chk_en)     par <= par ^ chk_bit;
  end
  assign chk_ok = ~par;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic b; int off; } bit_t;
  typedef struct { logic id; logic res; } done_t;

  logic [1:0] exp_gnt[$];
  bit_t       exp_bits[$];
  done_t      exp_done[$];
  int         last_gnt = 0;

  // Monitor: pops expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != 2'b00) begin
        if (exp_gnt.size() == 0) chk("gnt_unexpected", {30'd0, gnt}, 32'd0);
        else begin
          chk("gnt", {30'd0, gnt}, {30'd0, exp_gnt.pop_front()});
          chk("busy_at_gnt", {31'd0, busy}, 32'd1);
        end
        last_gnt = cyc;
      end
      if (chk_en) begin
        if (exp_bits.size() == 0) chk("bit_unexpected", 32'd1, 32'd0);
        else begin
          bit_t e;
          e = exp_bits.pop_front();
          chk("chk_bit", {31'd0, chk_bit}, {31'd0, e.b});
          chk("bit_offset", cyc - last_gnt, e.off);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else begin
          done_t d;
          d = exp_done.pop_front();
          chk("done_id", {31'd0, done_id}, {31'd0, d.id});
          chk("result", {31'd0, result}, {31'd0, d.res});
          chk("done_latency", cyc - last_gnt, 32'd10);
          chk("busy_at_done", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  task automatic push_word(input logic [1:0] g, input logic [7:0] w, input logic id, input logic res);
    exp_gnt.push_back(g);
    for (int i = 0; i < 8; i++) begin
      bit_t e;
      e.b = w[7-i];
      e.off = i + 1;
      exp_bits.push_back(e);
    end
    begin
      done_t d;
      d.id = id;
      d.res = res;
      exp_done.push_back(d);
    end
  endtask

  // Wait (bounded) for any grant; returns the grant vector and its cycle.
  task automatic wait_gnt(output logic [1:0] g, output int at);
    g = 2'b00;
    at = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        g = gnt;
        at = cyc;
        break;
      end
    end
    if (g == 2'b00) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_done.size() != 0 || exp_gnt.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  logic [1:0] g;
  int at, prev_at;

  initial begin
    // 1 reset with requests pending
    req = 2'b11;
    data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", {22'd0, gnt, busy, done, done_id, result, chk_restart, chk_en, chk_bit}, 32'd0);
    end
    req = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {30'd0, gnt}, 32'd0);

    // 2 single request, A5 has four ones -> pass
    push_word(2'b01, 8'hA5, 1'b0, 1'b1);
    data = 16'h00A5;
    req = 2'b01;
    wait_gnt(g, at);
    req = 2'b00;
    wait_drain();

    // 4 fail path from requester 1 (one 1 bit)
    push_word(2'b10, 8'h01, 1'b1, 1'b0);
    data = 16'h0100;
    req = 2'b10;
    wait_gnt(g, at);
    req = 2'b00;
    wait_drain();
    repeat (3) @(negedge clk);
    chk("done_id_hold", {31'd0, done_id}, 32'd1);
    chk("result_hold", {31'd0, result}, 32'd0);

    // 3 round-robin with both requesting: 03 passes, 07 fails
    data = 16'h0703;
    push_word(2'b01, 8'h03, 1'b0, 1'b1);
    push_word(2'b10, 8'h07, 1'b1, 1'b0);
    push_word(2'b01, 8'h03, 1'b0, 1'b1);
    push_word(2'b10, 8'h07, 1'b1, 1'b0);
    req = 2'b11;
    prev_at = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g, at);
      req = req & ~g;
      if (k > 0) chk("rr_spacing", at - prev_at, 32'd12);
      prev_at = at;
      @(negedge clk);
      if (k < 2) req = req | g;
    end
    wait_drain();

    // 5 abort by reset during SHIFT at cnt=3
    exp_gnt.push_back(2'b01);
    begin
      bit_t e;
      e.b = 1'b1; e.off = 1; exp_bits.push_back(e);
      e.b = 1'b0; e.off = 2; exp_bits.push_back(e);
      e.b = 1'b1; e.off = 3; exp_bits.push_back(e);
      e.b = 1'b0; e.off = 4; exp_bits.push_back(e);
    end
    data = 16'h00A5;
    req = 2'b01;
    wait_gnt(g, at);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("abort_outputs", {22'd0, gnt, busy, done, done_id, result, chk_restart, chk_en, chk_bit}, 32'd0);
    chk("abort_bits_consumed", exp_bits.size(), 32'd0);
    push_word(2'b01, 8'hA5, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(g, at);
    req = 2'b00;
    wait_drain();
    repeat (12) @(negedge clk);

    // 6 data changed during SHIFT must not affect the word in flight
    push_word(2'b01, 8'h3C, 1'b0, 1'b1);
    data = 16'h003C;
    req = 2'b01;
    wait_gnt(g, at);
    req = 2'b00;
    repeat (2) @(negedge clk);
    data = 16'hFFFE;
    wait_drain();

    chk("queues_empty", exp_gnt.size() + exp_bits.size() + exp_done.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
